// File: rtl/trace_sched.sv
// trace_sched: round-robin scheduler granting one scoring engine to a requester for a whole wallet.
// Optional idle-owner timeout/abort is enabled by defining TRACE_SCHED_TIMEOUT_EN.
module trace_sched #(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 7,
  parameter int TS_W        = 10,
  parameter int VAL_W       = 30,
  parameter int TIMEOUT_CYC = 1023,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [2*N_REQ-1:0]      req_method_i,
  input  logic [N_REQ-1:0]        req_in_i,
  input  logic [VAL_W*N_REQ-1:0]  req_value_i,
  input  logic [TS_W*N_REQ-1:0]   req_time_stamp_i,
  input  logic [N_REQ-1:0]        req_close_i,
  output logic                    eng_valid_o,
  input  logic                    eng_ready_i,
  output logic [1:0]              eng_method_o,
  output logic                    eng_in_o,
  output logic [VAL_W-1:0]        eng_value_o,
  output logic [TS_W-1:0]         eng_time_stamp_o,
  output logic                    eng_close_o,
  output logic [ID_W-1:0]         eng_id_o,
  output logic                    eng_abort_o,
  input  logic                    eng_score_valid_i,
  input  logic [6:0]              eng_score_i,
  output logic                    score_valid_o,
  output logic [ID_W-1:0]         score_id_o,
  output logic [6:0]              score_o,
  output logic [CNT_W-1:0]        score_count_o
);

  typedef enum logic [1:0] {IDLE, LOCKED, ISSUE, WAIT_SCORE} state_t;

  // Transaction count at which the next issued transaction is forced to close the wallet.
  localparam logic [CNT_W-1:0] SAT_CNT = {{(CNT_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;
  logic [1:0]        method_q, method_d;
  logic              in_q, in_d;
  logic [VAL_W-1:0]  value_q, value_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              close_q, close_d;
  logic              score_valid_q, score_valid_d;
  logic [ID_W-1:0]   score_id_q, score_id_d;
  logic [6:0]        score_q, score_d;
  logic [CNT_W-1:0]  score_count_q, score_count_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   next_ptr;
  logic              close_now;
  int                sel;
  int                scan;

`ifdef TRACE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              eng_abort_q, eng_abort_d;
`endif

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = int'(rr_ptr_q) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!pick_found && req_valid_i[scan]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(scan);
      end
    end
  end

  assign sel       = int'(owner_q);
  assign next_ptr  = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign close_now = close_q | (txn_count_q == SAT_CNT);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    txn_count_d   = txn_count_q;
    method_d      = method_q;
    in_d          = in_q;
    value_d       = value_q;
    ts_d          = ts_q;
    close_d       = close_q;
    score_valid_d = 1'b0;
    score_id_d    = score_id_q;
    score_d       = score_q;
    score_count_d = score_count_q;
`ifdef TRACE_SCHED_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    eng_abort_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef TRACE_SCHED_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (req_valid_i[sel]) begin
          method_d = req_method_i[sel*2 +: 2];
          in_d     = req_in_i[sel];
          value_d  = req_value_i[sel*VAL_W +: VAL_W];
          ts_d     = req_time_stamp_i[sel*TS_W +: TS_W];
          close_d  = req_close_i[sel];
          state_d  = ISSUE;
`ifdef TRACE_SCHED_TIMEOUT_EN
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // Silent owner: drop its partial wallet and move arbitration on.
          eng_abort_d = 1'b1;
          txn_count_d = '0;
          rr_ptr_d    = next_ptr;
          idle_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (eng_ready_i) begin
          txn_count_d = txn_count_q + 1'b1;
          state_d     = close_now ? WAIT_SCORE : LOCKED;
        end
      end
      WAIT_SCORE: begin
        if (eng_score_valid_i) begin
          score_valid_d = 1'b1;
          score_d       = eng_score_i;
          score_id_d    = owner_q;
          score_count_d = txn_count_q;
          rr_ptr_d      = next_ptr;
          txn_count_d   = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset drops any partial wallet silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      txn_count_q   <= '0;
      method_q      <= '0;
      in_q          <= 1'b0;
      value_q       <= '0;
      ts_q          <= '0;
      close_q       <= 1'b0;
      score_valid_q <= 1'b0;
      score_id_q    <= '0;
      score_q       <= '0;
      score_count_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      txn_count_q   <= txn_count_d;
      method_q      <= method_d;
      in_q          <= in_d;
      value_q       <= value_d;
      ts_q          <= ts_d;
      close_q       <= close_d;
      score_valid_q <= score_valid_d;
      score_id_q    <= score_id_d;
      score_q       <= score_d;
      score_count_q <= score_count_d;
    end
  end

`ifdef TRACE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_q  <= '0;
      eng_abort_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      eng_abort_q <= eng_abort_d;
    end
  end

  assign eng_abort_o = eng_abort_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
  assign eng_abort_o    = 1'b0;
`endif

  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) req_ready_o[sel] = 1'b1;
  end

  assign eng_valid_o      = (state_q == ISSUE);
  assign eng_close_o      = (state_q == ISSUE) & close_now;
  assign eng_method_o     = method_q;
  assign eng_in_o         = in_q;
  assign eng_value_o      = value_q;
  assign eng_time_stamp_o = ts_q;
  assign eng_id_o         = owner_q;
  assign score_valid_o    = score_valid_q;
  assign score_id_o       = score_id_q;
  assign score_o          = score_q;
  assign score_count_o    = score_count_q;

endmodule

// File: doc/trace_sched.md
# trace_sched

Round-robin scheduler that shares one transaction-scoring engine among `N_REQ` wallet-trace requesters. A requester is granted the engine for a whole wallet: every transaction up to and including its close transaction, then the returned 7-bit confidence score. Only then is the engine released to the next requester. The block sits between the per-source transaction feeds and the scoring datapath and sequences all traffic into it.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 7, per-wallet transaction counter width
- `TS_W`, 10, timestamp width
- `VAL_W`, 30, value width
- `TIMEOUT_CYC`, 1023, idle-owner timeout in cycles (used only with the timeout feature)

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `req_valid` in N_REQ — transaction offered by requester i
- `req_ready` out N_REQ — transaction accepted from requester i
- `req_method` in 2*N_REQ — method field (00 standard, 01 tether, 10 monero, 11 other); slice i
- `req_in` in N_REQ — direction bit (1 inbound, 0 outbound)
- `req_value` in VAL_W*N_REQ — transaction value
- `req_time_stamp` in TS_W*N_REQ — transaction timestamp
- `req_close` in N_REQ — marks the last transaction of the wallet
- `eng_valid` out 1 — transaction presented to the engine
- `eng_ready` in 1 — engine accepts it
- `eng_method`/`eng_in`/`eng_value`/`eng_time_stamp` out 2/1/VAL_W/TS_W — captured fields
- `eng_close` out 1 — close marker, possibly forced
- `eng_id` out clog2(N_REQ) — current owner
- `eng_abort` out 1 — one-cycle pulse; the engine discards its accumulated state
- `eng_score_valid` in 1, `eng_score` in 7 — result from the engine
- `score_valid` out 1, `score_id` out clog2(N_REQ), `score` out 7, `score_count` out CNT_W — result returned to requesters

## Operation
- FSM states are IDLE, LOCKED, ISSUE and WAIT_SCORE; the state is registered.
- **IDLE:** if any `req_valid` is set, latch `owner` as the first asserted index at or after `rr_ptr` (wrapping modulo N_REQ), then go to LOCKED.
- **LOCKED:**
  - `req_ready[owner]` = 1; every other bit is 0.
  - On `req_valid[owner]`, capture all fields into holding registers and go to ISSUE.
  - `req_valid` of non-owners is ignored.
- **ISSUE:**
  - `eng_valid` = 1; the fields are held stable until `eng_ready`.
  - On `eng_ready`, `txn_count` increments.
  - If `eng_close` = 1, go to WAIT_SCORE; otherwise go to LOCKED.
- **Forced close:** `eng_close` = captured close OR (`txn_count` == 2^CNT_W − 2). The 127th transaction of a wallet therefore always closes it.
- **WAIT_SCORE:**
  - On `eng_score_valid`, pulse `score_valid` for 1 cycle with `score` = `eng_score`, `score_id` = `owner`, `score_count` = `txn_count`.
  - Then `rr_ptr` ← (`owner` + 1) mod N_REQ, `txn_count` ← 0, go to IDLE.
- `eng_score_valid` in any state other than WAIT_SCORE is ignored.
- `score`, `score_id` and `score_count` hold their value until the next result.
- A requester must hold `req_valid` and its fields until it sees `req_ready`. The scheduler does not check this.

## Timing
- **Reset values:** state IDLE; `req_ready`, `eng_valid`, `eng_abort`, `score_valid` = 0; `eng_*` data, `eng_id`, `score`, `score_id`, `score_count`, `owner`, `rr_ptr`, `txn_count` = 0.
- All outputs are registered or decoded from registered state. There is no combinational input→output path.
- **Arbitration:** request seen in IDLE → `req_ready` high 1 cycle later.
- **Accept → engine:** `req_valid && req_ready` at edge k → `eng_valid` high from cycle k+1.
- **Throughput:** best case 2 cycles per transaction (LOCKED → ISSUE → LOCKED).
- **Score return:** `eng_score_valid` at edge k → `score_valid` high at cycle k+1. The next arbitration happens in IDLE at k+1; `req_ready` goes high at k+2.
- **Reset mid-operation:** `eng_valid` and `req_ready` drop asynchronously; any partial wallet is dropped with no `eng_abort`.
- **Wrap-around:** `owner` = N_REQ−1 gives `rr_ptr` = 0.

## Configuration
- Macro: `TRACE_SCHED_TIMEOUT_EN`.
- **Defined:**
  - In LOCKED, an idle counter counts cycles without `req_valid[owner]`; the counter clears on any accept.
  - On reaching `TIMEOUT_CYC`, pulse `eng_abort` for 1 cycle, set `txn_count` ← 0, `rr_ptr` ← `owner` + 1, go to IDLE.
  - No `score_valid` is produced.
- **Undefined:** no counter; `eng_abort` is tied to 0; the owner holds the engine indefinitely.

## Test plan
- Single wallet: requester 2 sends 3 transactions, close on the third, with `eng_ready` = 1. Expect `eng_id` = 2 three times. Engine returns `eng_score` = 55. Expect `score_valid` 1 cycle, `score` = 55, `score_id` = 2, `score_count` = 3.
- Fairness: all 4 `req_valid` high, each wallet one closing transaction. Expect grant order 0, 1, 2, 3, 0.
- Backpressure: hold `eng_ready` = 0 for 5 cycles in ISSUE. Expect `eng_valid` and fields stable and `req_ready[owner]` = 0 throughout.
- Saturation: 127 non-close transactions from requester 1. Expect `eng_close` = 1 on the 127th, then WAIT_SCORE, and `score_count` = 127.
- Reset: assert `rst` in WAIT_SCORE. Expect all outputs at reset values immediately; a later `eng_score_valid` is ignored.
- With `TRACE_SCHED_TIMEOUT_EN` and `TIMEOUT_CYC` = 8: owner 0 sends 1 non-close transaction then goes silent. Expect `eng_abort` pulse 8 cycles after LOCKED re-entry, then requester 1 granted.
